// File: rtl/pipe_ctrl_if.sv
// Bundle of status and latch-control signals between the datapath (master)
// and the pipeline controller (slave).
interface pipe_ctrl_if;
    logic        ihit;
    logic        dhit;
    logic        idex_DRen;
    logic        idex_RegW;
    logic [4:0]  idex_wsel;
    logic        exmem_DRen;
    logic        exmem_DWen;
    logic        exmem_RegW;
    logic [4:0]  exmem_wsel;
    logic        br_taken;
    logic        jr_mem;
    logic        halt_mem;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        jump_id;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        dmemREN;
    logic        dmemWEN;
    logic        halt;
    logic [15:0] stall_cnt;

    modport master (
        output ihit, dhit, idex_DRen, idex_RegW, idex_wsel,
               exmem_DRen, exmem_DWen, exmem_RegW, exmem_wsel,
               br_taken, jr_mem, halt_mem,
               ifid_rs, ifid_rt, ifid_uses_rt, jump_id,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush,
               dmemREN, dmemWEN, halt, stall_cnt
    );

    modport slave (
        input  ihit, dhit, idex_DRen, idex_RegW, idex_wsel,
               exmem_DRen, exmem_DWen, exmem_RegW, exmem_wsel,
               br_taken, jr_mem, halt_mem,
               ifid_rs, ifid_rt, ifid_uses_rt, jump_id,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush,
               dmemREN, dmemWEN, halt, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/stall controller with RUN/DWAIT/HALT FSM.
// Define PIPE_FWD_EN when the datapath forwards results: only load-use then stalls.
module pipe_ctrl (
    input  logic        CLK,
    input  logic        RST,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        acc_done_q, acc_done_d;
    logic        halt_q, halt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic dstall;
    logic freeze;
    logic redirect;
    logic load_use;
    logic hazard;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic dmem_ren, dmem_wen;

    function automatic logic src_match(input logic [4:0] wsel,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (wsel != 5'd0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
    endfunction

    always_comb begin
        dstall   = (bus.exmem_DRen | bus.exmem_DWen) & ~bus.dhit & ~acc_done_q;
        freeze   = dstall | ~bus.ihit;
        redirect = bus.br_taken | bus.jr_mem;
        load_use = bus.idex_DRen & bus.idex_RegW &
                   src_match(bus.idex_wsel, bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt);
    end

`ifdef PIPE_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^{bus.exmem_RegW, bus.exmem_wsel};
    assign hazard = load_use;
`else
    // Without forwarding any pending register write in EX or MEM blocks ID.
    assign hazard = load_use
        | (bus.idex_RegW  & src_match(bus.idex_wsel,  bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt))
        | (bus.exmem_RegW & src_match(bus.exmem_wsel, bus.ifid_rs, bus.ifid_rt, bus.ifid_uses_rt));
`endif

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dmem_ren    = bus.exmem_DRen & ~acc_done_q;
        dmem_wen    = bus.exmem_DWen & ~acc_done_q;

        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
            dmem_ren = 1'b0;
            dmem_wen = 1'b0;
        end else if (state_q == HALT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            dmem_ren = 1'b0;
            dmem_wen = 1'b0;
        end else if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        end else if (redirect) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (bus.jump_id) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.halt_mem && !freeze) state_d = HALT;
                else if (dstall)             state_d = DWAIT;
            end
            DWAIT: begin
                if (bus.halt_mem && !freeze) state_d = HALT;
                else if (!dstall)            state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase

        // A completed access is remembered until MEM actually advances.
        acc_done_d = acc_done_q;
        if (memwb_en)
            acc_done_d = 1'b0;
        else if (freeze && bus.dhit && state_q != HALT)
            acc_done_d = 1'b1;

        halt_d = (state_d == HALT);

        stall_cnt_d = stall_cnt_q;
        if (state_q != HALT && !pc_en && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            acc_done_q  <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            acc_done_q  <= acc_done_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.dmemREN     = dmem_ren;
    assign bus.dmemWEN     = dmem_wen;
    assign bus.halt        = halt_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected latch controls are queued
// when inputs are driven and compared on the falling edge.
module tb_pipe_ctrl;

    logic CLK = 1'b0;
    logic RST;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Control vector order: pc, ifid, idex, exmem, memwb enables, then ifid/idex/exmem flushes
    localparam logic [7:0] NORMAL = 8'b11111_000;
    localparam logic [7:0] FREEZE = 8'b00000_000;
    localparam logic [7:0] REDIR  = 8'b11111_111;
    localparam logic [7:0] LU     = 8'b00111_010;
    localparam logic [7:0] JUMP   = 8'b11111_100;
    localparam logic [7:0] RSTV   = 8'b00000_111;

    typedef struct {
        logic [7:0]  ctrl;
        logic [1:0]  dmem;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt = 16'd0;
    int          checks  = 0;
    int          errors  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ihit = 1'b1;       bus.dhit = 1'b0;
        bus.idex_DRen = 1'b0;  bus.idex_RegW = 1'b0;  bus.idex_wsel = 5'd0;
        bus.exmem_DRen = 1'b0; bus.exmem_DWen = 1'b0; bus.exmem_RegW = 1'b0;
        bus.exmem_wsel = 5'd0; bus.br_taken = 1'b0;   bus.jr_mem = 1'b0;
        bus.halt_mem = 1'b0;   bus.ifid_rs = 5'd0;    bus.ifid_rt = 5'd0;
        bus.ifid_uses_rt = 1'b0; bus.jump_id = 1'b0;
    endtask

    task automatic loadUse(input logic [4:0] wsel, input logic [4:0] rs);
        bus.idex_DRen = 1'b1;
        bus.idex_RegW = 1'b1;
        bus.idex_wsel = wsel;
        bus.ifid_rs   = rs;
    endtask

    // One clock: queue expectation, compare mid-cycle, then advance the counter model.
    task automatic applyStimulus(input string tag, input logic [7:0] ctrl,
                                 input logic [1:0] dmem, input logic halt);
        exp_t e;
        exp_t got;
        e.ctrl = ctrl; e.dmem = dmem; e.halt = halt; e.cnt = exp_cnt;
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        checkOutput({tag, "_ctrl"},
                    {24'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, {24'd0, got.ctrl});
        checkOutput({tag, "_dmem"}, {30'd0, bus.dmemREN, bus.dmemWEN}, {30'd0, got.dmem});
        checkOutput({tag, "_halt"}, {31'd0, bus.halt}, {31'd0, got.halt});
        checkOutput({tag, "_cnt"},  {16'd0, bus.stall_cnt}, {16'd0, got.cnt});
        if (RST)
            exp_cnt = 16'd0;
        else if (!halt && !ctrl[7] && exp_cnt != 16'hFFFF)
            exp_cnt = exp_cnt + 16'd1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus("reset", RSTV, 2'b00, 1'b0);
        RST = 1'b0;
        applyStimulus("normal", NORMAL, 2'b00, 1'b0);

        loadUse(5'd5, 5'd5);
        applyStimulus("loaduse", LU, 2'b00, 1'b0);
        idle();
        applyStimulus("after_lu", NORMAL, 2'b00, 1'b0);
        checkOutput("cnt_lu_one", {16'd0, bus.stall_cnt}, 32'd1);

        loadUse(5'd0, 5'd0);
        applyStimulus("lu_r0", NORMAL, 2'b00, 1'b0);
        idle();
        loadUse(5'd7, 5'd1);
        bus.ifid_rt = 5'd7;
        applyStimulus("lu_rt_unused", NORMAL, 2'b00, 1'b0);
        bus.ifid_uses_rt = 1'b1;
        applyStimulus("lu_rt_used", LU, 2'b00, 1'b0);

        idle();
        bus.exmem_DRen = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("dwait", FREEZE, 2'b10, 1'b0);
        bus.dhit = 1'b1;
        applyStimulus("dhit", NORMAL, 2'b10, 1'b0);

        idle();
        bus.exmem_DWen = 1'b1; bus.ihit = 1'b0; bus.dhit = 1'b1;
        applyStimulus("st_ihit0", FREEZE, 2'b01, 1'b0);
        bus.dhit = 1'b0;
        applyStimulus("st_done1", FREEZE, 2'b00, 1'b0);
        applyStimulus("st_done2", FREEZE, 2'b00, 1'b0);
        bus.ihit = 1'b1;
        applyStimulus("st_release", NORMAL, 2'b00, 1'b0);
        applyStimulus("st_next", FREEZE, 2'b01, 1'b0);
        bus.dhit = 1'b1;
        applyStimulus("st_next_hit", NORMAL, 2'b01, 1'b0);

        idle();
        bus.jump_id = 1'b1;
        applyStimulus("jump", JUMP, 2'b00, 1'b0);
        loadUse(5'd9, 5'd9);
        applyStimulus("jump_lu", LU, 2'b00, 1'b0);
        bus.br_taken = 1'b1;
        applyStimulus("br_over_lu", REDIR, 2'b00, 1'b0);
        idle();
        bus.jr_mem = 1'b1;
        applyStimulus("jr", REDIR, 2'b00, 1'b0);
        bus.ihit = 1'b0;
        applyStimulus("jr_frozen", FREEZE, 2'b00, 1'b0);

        idle();
        bus.exmem_RegW = 1'b1; bus.exmem_wsel = 5'd8;
        bus.ifid_rt = 5'd8;    bus.ifid_uses_rt = 1'b1;
`ifdef PIPE_FWD_EN
        applyStimulus("mem_dep", NORMAL, 2'b00, 1'b0);
`else
        applyStimulus("mem_dep", LU, 2'b00, 1'b0);
`endif
        idle();
        bus.idex_RegW = 1'b1; bus.idex_wsel = 5'd3; bus.ifid_rs = 5'd3;
`ifdef PIPE_FWD_EN
        applyStimulus("ex_dep", NORMAL, 2'b00, 1'b0);
`else
        applyStimulus("ex_dep", LU, 2'b00, 1'b0);
`endif

        idle();
        bus.halt_mem = 1'b1; bus.ihit = 1'b0;
        applyStimulus("halt_frozen", FREEZE, 2'b00, 1'b0);
        bus.ihit = 1'b1;
        applyStimulus("halt_mem", NORMAL, 2'b00, 1'b0);
        idle();
        bus.exmem_DRen = 1'b1;
        loadUse(5'd4, 5'd4);
        for (int i = 0; i < 10; i++) applyStimulus("halted", FREEZE, 2'b00, 1'b1);
        RST = 1'b1;
        applyStimulus("halt_rst", RSTV, 2'b00, 1'b1);
        RST = 1'b0;
        idle();
        applyStimulus("post_halt", NORMAL, 2'b00, 1'b0);

        bus.exmem_DRen = 1'b1;
        applyStimulus("dw_a", FREEZE, 2'b10, 1'b0);
        applyStimulus("dw_b", FREEZE, 2'b10, 1'b0);
        RST = 1'b1;
        applyStimulus("dw_rst", RSTV, 2'b00, 1'b0);
        RST = 1'b0;
        idle();
        applyStimulus("post_dw", NORMAL, 2'b00, 1'b0);

        bus.ihit = 1'b0;
        repeat (65540) @(posedge CLK);
        #1;
        exp_cnt = 16'hFFFF;
        applyStimulus("sat", FREEZE, 2'b00, 1'b0);
        bus.ihit = 1'b1;
        applyStimulus("sat_hold", NORMAL, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
